axi_read_burst_scheduler: RTL
=============================

Name: axi_read_burst_scheduler

Overview:
- Sequences a kernel's AXI4 read-address channel.
- Splits a host-programmed transfer (start address, length in beats) into bursts of at most C_BURST_LEN beats.
- Caps in-flight bursts at C_MAX_OUTSTANDING using an internal up/down outstanding-burst counter.
- Signals completion after the last burst's final beat returns. Sits between the kernel control registers and the AXI master read channel.

Parameters:
- C_ADDR_WIDTH, 64, byte address width.
- C_XFER_SIZE_WIDTH, 32, width of the transfer length in beats.
- C_BURST_LEN, 64, maximum beats per burst (1..256).
- C_BYTES_PER_BEAT, 64, data bus width in bytes (power of 2).
- C_MAX_OUTSTANDING, 16, maximum bursts issued but not yet completed (1..255).

Ports:
- aclk  in  1  clock.
- areset  in  1  reset, asynchronous, active-high.
- ctrl_start  in  1  one-cycle start pulse.
- ctrl_addr_offset  in  C_ADDR_WIDTH  start byte address, aligned to C_BYTES_PER_BEAT.
- ctrl_xfer_beats  in  C_XFER_SIZE_WIDTH  total beats to read.
- ctrl_busy  out  1  high from start acceptance until the done pulse, inclusive.
- ctrl_done  out  1  one-cycle completion pulse.
- arvalid  out  1  AXI read-address valid.
- arready  in  1  AXI read-address ready.
- araddr  out  C_ADDR_WIDTH  burst start address.
- arlen  out  8  burst beats minus 1.
- burst_done  in  1  one-cycle pulse per completed burst (rvalid & rready & rlast).
- outstanding  out  8  bursts currently in flight.

Behaviour:
- Reset (async assert, sync release): state IDLE; arvalid=0, araddr=0, arlen=0, ctrl_busy=0, ctrl_done=0, outstanding=0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - ctrl_start=1 latches addr/beats, sets ctrl_busy the next cycle, and moves to ISSUE.
  - If beats==0, moves to DONE instead.
  - ctrl_start in any state other than IDLE is ignored.
- ISSUE:
  - arvalid asserts only when bursts_remaining>0 and outstanding<C_MAX_OUTSTANDING.
  - First arvalid is no earlier than 1 cycle after start acceptance.
  - Once arvalid=1, arvalid/araddr/arlen stay stable until arvalid&arready. No withdrawal; the outstanding limit is checked only before assertion.
  - On handshake: remaining -= burst beats; araddr += C_BURST_LEN*C_BYTES_PER_BEAT (modulo 2^C_ADDR_WIDTH, wrap allowed).
  - arlen = min(remaining, C_BURST_LEN) - 1. Only the final burst may be short.
  - arvalid may reassert the cycle after a handshake (back-to-back, 1 burst/cycle max).
  - After the last burst's handshake: move to DRAIN.
- DRAIN: when outstanding==0 and no burst_done is pending, move to DONE.
- DONE: ctrl_done=1 for exactly one cycle, ctrl_busy deasserts with it, then return to IDLE.
- Outstanding counter:
  - Increments on arvalid&arready; decrements on burst_done.
  - Both in the same cycle: unchanged.
  - burst_done with outstanding==0 is ignored; the counter never underflows.
  - The counter never exceeds C_MAX_OUTSTANDING.
- Number of bursts = ceil(beats / C_BURST_LEN). Beat arithmetic is done at C_XFER_SIZE_WIDTH+1 bits, so there is no overflow.
- areset mid-transfer: immediately returns to reset values. Any in-flight AXI transactions are the system's responsibility.

Test Plan:
- beats=150, addr=0x1000, defaults, arready=1, burst_done 10 cycles after each AR → arlen 63,63,21; araddr 0x1000,0x2000,0x3000; single ctrl_done after the third burst_done; ctrl_busy low after.
- beats=0 → no arvalid; ctrl_done pulses 2 cycles after start; ctrl_busy high exactly 1 cycle before and during done.
- C_MAX_OUTSTANDING=2, beats=320, arready=1, burst_done withheld → exactly 2 ARs, outstanding=2, arvalid stays 0; one burst_done → third AR next cycle.
- arready low for 5 cycles while arvalid=1 → araddr/arlen stable for all 5 cycles; one handshake; outstanding 0→1.
- Same-cycle AR handshake and burst_done with outstanding=3 → outstanding stays 3; stray burst_done at outstanding=0 → stays 0.
- addr=0xFFFF_FFFF_FFFF_F000, beats=128 → second araddr wraps to 0x0; ctrl_start mid-transfer ignored; areset mid-ISSUE → arvalid=0 and outstanding=0 immediately.

Source files
------------

// File: rtl/axi_read_burst_scheduler.sv
// axi_read_burst_scheduler: splits a host transfer into AXI4 read bursts with an outstanding-burst cap
module axi_read_burst_scheduler #(
   parameter int C_ADDR_WIDTH      = 64,
   parameter int C_XFER_SIZE_WIDTH = 32,
   parameter int C_BURST_LEN       = 64,
   parameter int C_BYTES_PER_BEAT  = 64,
   parameter int C_MAX_OUTSTANDING = 16
) (
   input  logic                         i_aclk,
   input  logic                         i_areset,
   input  logic                         i_ctrl_start,
   input  logic [C_ADDR_WIDTH-1:0]      i_ctrl_addr_offset,
   input  logic [C_XFER_SIZE_WIDTH-1:0] i_ctrl_xfer_beats,
   output logic                         o_ctrl_busy,
   output logic                         o_ctrl_done,
   output logic                         o_arvalid,
   input  logic                         i_arready,
   output logic [C_ADDR_WIDTH-1:0]      o_araddr,
   output logic [7:0]                   o_arlen,
   input  logic                         i_burst_done,
   output logic [7:0]                   o_outstanding
);
   localparam int LP_RW = C_XFER_SIZE_WIDTH + 1;
   localparam logic [C_ADDR_WIDTH-1:0] LP_ADDR_INC = C_ADDR_WIDTH'(C_BURST_LEN * C_BYTES_PER_BEAT);
   localparam logic [LP_RW-1:0] LP_BURST = LP_RW'(C_BURST_LEN);
   localparam logic [7:0] LP_MAX = 8'(C_MAX_OUTSTANDING);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
   state_t                  r_state;
   logic [LP_RW-1:0]        r_remaining;
   logic [C_ADDR_WIDTH-1:0] r_araddr;
   logic [7:0]              r_arlen;
   logic                    r_arvalid;
   logic                    r_busy;
   logic                    r_done;
   logic [7:0]              r_outstanding;
   logic                    w_hs;
   logic                    w_dec;
   logic                    w_issue_ok;
   logic [7:0]              w_cnt_next;
   logic [7:0]              w_next_len;
   logic [LP_RW-1:0]        w_cur_beats;
   logic [LP_RW-1:0]        w_rem_next;
   logic [LP_RW-1:0]        w_next_beats;
   assign o_arvalid     = r_arvalid;
   assign o_araddr      = r_araddr;
   assign o_arlen       = r_arlen;
   assign o_ctrl_busy   = r_busy;
   assign o_ctrl_done   = r_done;
   assign o_outstanding = r_outstanding;
   // Next-cycle view of the counter and remaining beats; issuing against the
   // next counter value lets a freed slot or a handshake reissue immediately.
   always_comb begin
      w_hs         = r_arvalid & i_arready;
      w_dec        = i_burst_done & (r_outstanding != 8'd0);
      w_cnt_next   = r_outstanding + {7'd0, w_hs} - {7'd0, w_dec};
      w_cur_beats  = LP_RW'(r_arlen) + LP_RW'(1);
      w_rem_next   = w_hs ? r_remaining - w_cur_beats : r_remaining;
      w_next_beats = (w_rem_next > LP_BURST) ? LP_BURST : w_rem_next;
      w_next_len   = 8'(w_next_beats - LP_RW'(1));
      w_issue_ok   = (w_rem_next != '0) && (w_cnt_next < LP_MAX);
   end
   // Outstanding-burst counter; a completion with nothing in flight is dropped.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) r_outstanding <= '0;
      else          r_outstanding <= w_cnt_next;
   end
   // Control FSM with registered AR channel and status outputs.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_araddr    <= '0;
         r_arlen     <= '0;
         r_arvalid   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_ctrl_start) begin
                  r_busy      <= 1'b1;
                  r_araddr    <= i_ctrl_addr_offset;
                  r_remaining <= {1'b0, i_ctrl_xfer_beats};
                  r_state     <= (i_ctrl_xfer_beats == '0) ? S_DONE : S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!r_arvalid || w_hs) begin
                  r_arvalid <= w_issue_ok;
                  if (w_issue_ok) r_arlen <= w_next_len;
                  if (w_hs) begin
                     r_remaining <= w_rem_next;
                     r_araddr    <= r_araddr + LP_ADDR_INC;
                  end
                  if (w_rem_next == '0) r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (r_outstanding == 8'd0 && !i_burst_done) r_state <= S_DONE;
            end
            S_DONE: begin
               if (!r_done) begin
                  r_done <= 1'b1;
               end else begin
                  r_done  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
